// File: rtl/beta_loader_pkg.sv
// Shared types and constants for the beta memory loader.
// No logic: state encoding, command bytes and a small elaboration helper.
// Imported by beta_mem_loader and beta_word_packer.
package beta_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WR     = 3'd4
  } state_e;

  // Command bytes recognised in IDLE
  localparam logic [7:0] CMD_IMEM = 8'h49;  // 'I'
  localparam logic [7:0] CMD_DMEM = 8'h44;  // 'D'
  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'

  // Elaboration-time maximum, used to size shared datapaths
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/beta_word_packer.sv
// Byte-to-word shift register: first byte ends up in the MSBs of the word.
// Latency: word_nxt/last are combinational on the byte being accepted; state updates next edge.
// Backpressure: none of its own; the parent only presents byte_vld on an accepted handshake.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clear             drop any partial word and restart at byte 0
//   byte_vld/byte_dat byte accepted this cycle
//   bpw               bytes per word for the current target (runtime select)
//   word_nxt          word including the byte being accepted (valid when last=1)
//   last              the accepted byte completes a word
module beta_word_packer
  import beta_loader_pkg::*;
#(
  parameter int W  = 128,
  parameter int CW = $clog2(W / 8 + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          byte_vld,
  input  logic [7:0]    byte_dat,
  input  logic [CW-1:0] bpw,
  output logic [W-1:0]  word_nxt,
  output logic          last
);

  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] idx_q, idx_d;

  // Shifting left means the earliest byte migrates toward the MSB. For a
  // narrower target only the low bpw*8 bits are used by the parent, so stale
  // upper bits from an earlier wide word are harmless.
  assign word_nxt = {shift_q[W-9:0], byte_dat};
  assign last     = byte_vld && ((idx_q + CW'(1)) == bpw);

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_vld) begin
      shift_d = word_nxt;
      idx_d   = last ? '0 : idx_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/beta_mem_loader.sv
// Command-stream loader: parses I/D/G commands and writes packed words into im or dm.
// Latency: im_we/dm_we assert exactly one cycle after the last byte of a word is accepted.
// Backpressure: in_ready drops only during the single WR cycle after each completed word.
//
// Ports:
//   clk, RESET_N                 clock, async active-low reset
//   in_data/in_valid/in_ready    byte stream, valid/ready handshake
//   im_we/im_addr/im_wdata       instruction memory write port (one-cycle strobe)
//   dm_we/dm_addr/dm_wdata       data memory write port (one-cycle strobe)
//   cpu_hold                     1 keeps the beta core in reset until 'G'
//   err                          one-cycle pulse on an unknown command byte
//   busy                         1 while a load command is in progress
module beta_mem_loader
  import beta_loader_pkg::*;
#(
  parameter int IM_AW = 10,
  parameter int DM_AW = 8,
  parameter int IM_W  = 32,
  parameter int DM_W  = 128
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             im_we,
  output logic [IM_AW-1:0] im_addr,
  output logic [IM_W-1:0]  im_wdata,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [DM_W-1:0]  dm_wdata,
  output logic             cpu_hold,
  output logic             err,
  output logic             busy
);

  localparam int PW = max_int(IM_W, DM_W);
  localparam int AW = max_int(IM_AW, DM_AW);
  localparam int CW = $clog2(PW / 8 + 1);

  localparam logic [CW-1:0] IM_BPW = CW'(IM_W / 8);
  localparam logic [CW-1:0] DM_BPW = CW'(DM_W / 8);

  // FSM and datapath state
  state_e           state_q, state_d;
  logic             tgt_dm_q, tgt_dm_d;     // 1 = current load targets dm
  logic [15:0]      count_q, count_d;       // words remaining in this load
  logic [AW-1:0]    wa_q, wa_d;             // running word address
  logic             im_we_q, im_we_d;
  logic [IM_AW-1:0] im_addr_q, im_addr_d;
  logic [IM_W-1:0]  im_wdata_q, im_wdata_d;
  logic             dm_we_q, dm_we_d;
  logic [DM_AW-1:0] dm_addr_q, dm_addr_d;
  logic [DM_W-1:0]  dm_wdata_q, dm_wdata_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             err_q, err_d;

  // Packer interface
  logic             acc;
  logic             pk_vld;
  logic             pk_clr;
  logic [CW-1:0]    pk_bpw;
  logic [PW-1:0]    pk_word;
  logic             pk_last;
  logic [15:0]      len_full;

  assign in_ready = (state_q != ST_WR);
  assign busy     = (state_q != ST_IDLE);
  assign acc      = in_valid && in_ready;
  assign pk_vld   = acc && (state_q == ST_DATA);
  // Restart the packer when a non-empty load begins so a word abandoned by an
  // earlier command can never leak into the new one.
  assign pk_clr   = acc && (state_q == ST_LEN_LO);
  assign pk_bpw   = tgt_dm_q ? DM_BPW : IM_BPW;
  assign len_full = {count_q[15:8], in_data};

  beta_word_packer #(
    .W  (PW),
    .CW (CW)
  ) u_packer (
    .clk      (clk),
    .rst_n    (RESET_N),
    .clear    (pk_clr),
    .byte_vld (pk_vld),
    .byte_dat (in_data),
    .bpw      (pk_bpw),
    .word_nxt (pk_word),
    .last     (pk_last)
  );

  always_comb begin
    state_d    = state_q;
    tgt_dm_d   = tgt_dm_q;
    count_d    = count_q;
    wa_d       = wa_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    dm_we_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    cpu_hold_d = cpu_hold_q;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (in_data == CMD_IMEM) begin
            tgt_dm_d   = 1'b0;
            cpu_hold_d = 1'b1;
            state_d    = ST_LEN_HI;
          end else if (in_data == CMD_DMEM) begin
            tgt_dm_d   = 1'b1;
            cpu_hold_d = 1'b1;
            state_d    = ST_LEN_HI;
          end else if (in_data == CMD_GO) begin
            cpu_hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LEN_HI: begin
        if (acc) begin
          count_d = {in_data, count_q[7:0]};
          state_d = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (acc) begin
          count_d = len_full;
          if (len_full == 16'd0) begin
            state_d = ST_IDLE;
          end else begin
            wa_d    = '0;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        // Address and data are captured here so they are already stable in the
        // WR cycle when the strobe is high, and they hold afterwards.
        if (pk_last) begin
          state_d = ST_WR;
          if (tgt_dm_q) begin
            dm_we_d    = 1'b1;
            dm_addr_d  = wa_q[DM_AW-1:0];
            dm_wdata_d = pk_word[DM_W-1:0];
          end else begin
            im_we_d    = 1'b1;
            im_addr_d  = wa_q[IM_AW-1:0];
            im_wdata_d = pk_word[IM_W-1:0];
          end
        end
      end

      ST_WR: begin
        // Truncating wa_q to the target width gives the mod-depth wrap.
        count_d = count_q - 16'd1;
        wa_d    = wa_q + AW'(1);
        state_d = (count_q == 16'd1) ? ST_IDLE : ST_DATA;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      tgt_dm_q   <= 1'b0;
      count_q    <= '0;
      wa_q       <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      cpu_hold_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_dm_q   <= tgt_dm_d;
      count_q    <= count_d;
      wa_q       <= wa_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      err_q      <= err_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign err      = err_q;

endmodule

// File: doc/beta_mem_loader.md
Name: beta_mem_loader

Overview:
- Upstream loader stage for the unpipelined beta core.
- Receives a byte stream with a valid/ready handshake, decodes a small command protocol, packs bytes into 32-bit instruction words or 128-bit data words, and writes them into instruction memory (im) or data memory (dm).
- Drives cpu_hold, which is tied to the core's RESET. The core therefore stays in reset until the host issues GO.
- Replaces testbench preloading of im/dm on the FPGA.

Parameters:
IM_AW, 10, instruction memory word-address width
DM_AW, 8, data memory word-address width
IM_W, 32, instruction word width (multiple of 8)
DM_W, 128, data word width (multiple of 8)

Ports:
clk  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte this cycle
im_we  out  1  instruction memory write strobe, one-cycle pulse
im_addr  out  IM_AW  instruction word address
im_wdata  out  IM_W  instruction word
dm_we  out  1  data memory write strobe, one-cycle pulse
dm_addr  out  DM_AW  data word address
dm_wdata  out  DM_W  data word
cpu_hold  out  1  1 = hold beta in reset
err  out  1  one-cycle pulse on an unknown command byte
busy  out  1  1 while a load command is in progress (not IDLE)

Behaviour:
- Reset (RESET_N=0, async):
  - state=IDLE, cpu_hold=1, all strobes, err and busy 0.
  - Addresses, count, shift register and wdata all 0.
  - A partial word in flight is discarded.
- Handshake:
  - A byte is accepted on a rising clk with in_valid&in_ready.
  - in_ready=1 in every state except WR, which lasts one cycle after the final byte of each word.
- Commands (first byte in IDLE):
  - 0x49 'I': target = im.
  - 0x44 'D': target = dm.
  - 0x47 'G': cpu_hold<=0 next cycle, stay IDLE.
  - Any other byte: discarded, err pulses next cycle, stay IDLE.
  - Accepting 'I' or 'D' sets cpu_hold<=1 immediately (next edge).
- States:
  - IDLE -> LEN_HI on I/D.
  - LEN_HI -> LEN_LO: store count[15:8].
  - LEN_LO: store count[7:0]. If count==0, go to IDLE with no writes. Otherwise clear the word address and byte index, then go to DATA.
  - DATA: shift each byte in, first byte = MSB (word = {b0,b1,...}). On the last byte of a word (IM_W/8 or DM_W/8 bytes), go to WR.
  - WR (1 cycle): assert the target we with the packed word at the current address, decrement count, increment address (wraps mod 2^AW). Then count==0 -> IDLE, else -> DATA.
- Timing and width rules:
  - Latency: we asserts exactly 1 cycle after the handshake of the word's last byte.
  - Address/wdata stay valid while we=1 and hold afterwards.
  - count is 16 bits. A length greater than the memory depth wraps and overwrites from address 0.
  - im_we and dm_we are never asserted together.
- Stream gaps: in_valid low mid-word simply stalls; there is no timeout.
- 'G' inside a payload is treated as data, not as a command.
- Reset mid-load: cpu_hold returns to 1, and the next byte is parsed as a command.

Decomposition:
- Shared package beta_loader_pkg holds:
  - state encoding (IDLE, LEN_HI, LEN_LO, DATA, WR);
  - command constants CMD_IMEM=8'h49, CMD_DMEM=8'h44, CMD_GO=8'h47.
- One natural sub-module: beta_word_packer. It is a parameterized byte-to-word shift register with a byte counter and last-byte flag, instantiated once with width = max(IM_W, DM_W) and a runtime bytes-per-word select.

Test Plan:
- Reset then 'D',0x00,0x01, then 16 bytes aa 29 df 7d 19 6f 03 aa 5e 36 69 8b a5 69 b1 33 -> one dm_we pulse at dm_addr=0 with dm_wdata=128'haa29df7d196f03aa5e36698ba569b133; cpu_hold stays 1; im_we never asserts.
- 'I',0x00,0x02, then words 0x11223344 and 0x55667788 -> im_we at addr 0 with 32'h11223344, then at addr 1 with 32'h55667788; back to IDLE with busy=0.
- 'G' -> cpu_hold falls 1 cycle after acceptance; a following 'D',0x00,0x00 -> cpu_hold=1 again, no writes, busy returns to 0.
- Byte 0x5A in IDLE -> one-cycle err pulse, no state change; a subsequent 'I' is accepted normally.
- 'I' load with random in_valid gaps and a 0x47 byte inside the payload -> words are packed identically to the gap-free run, and cpu_hold stays 1.
- RESET_N pulsed low after 7 of 16 dm payload bytes -> no dm_we, cpu_hold=1. A new 'D',0x00,0x01 load then writes its word at addr 0.
